// File: rtl/page_swap_controller.sv
// Copies one page between the primary-memory page window and a numbered disk slot.
// Each word takes an RD cycle (source address out) and a WR cycle (destination write).
//   state  | meaning
//   S_IDLE | waiting for std/ldd, outputs hold, tr low
//   S_RD   | source address presented, read data arrives next cycle
//   S_WR   | destination written with the source read data
//   S_DONE | one-cycle completion pulse, requests ignored
module page_swap_controller #(
    parameter int DW      = 16,
    parameter int MEM_AW  = 16,
    parameter int DISK_AW = 15,
    parameter int PAGE_W  = 8,
    parameter int POS_W   = DISK_AW - PAGE_W,
    parameter logic [MEM_AW-1:0] MEM_BASE = 16'hFF00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               std_i,
    input  logic               ldd_i,
    input  logic [POS_W-1:0]   pos_i,
    output logic [MEM_AW-1:0]  addr_p_o,
    output logic [DW-1:0]      data_p_o,
    output logic               tr_p_o,
    input  logic [DW-1:0]      q_p_i,
    output logic [DISK_AW-1:0] addr_s_o,
    output logic [DW-1:0]      data_s_o,
    output logic               tr_s_o,
    input  logic [DW-1:0]      q_s_i,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic DIR_STORE = 1'b0;
    localparam logic DIR_LOAD  = 1'b1;
    localparam logic [PAGE_W-1:0] I_LAST = '1;

    state_t             state_q;
    logic [PAGE_W-1:0]  i_q;
    logic [PAGE_W-1:0]  i_d;
    logic [POS_W-1:0]   slot_q;
    logic [POS_W-1:0]   slot_d;
    logic               dir_q;
    logic [MEM_AW-1:0]  addr_p_q;
    logic [DISK_AW-1:0] addr_s_q;
    logic [DW-1:0]      data_p_q;
    logic [DW-1:0]      data_s_q;
    logic               tr_p_q;
    logic               tr_s_q;
    logic               busy_q;
    logic               done_q;
    logic [MEM_AW-1:0]  mem_addr_d;
    logic [DISK_AW-1:0] disk_addr_d;

    // Word index and slot for the address registered at the coming edge.
    always_comb begin
        i_d    = i_q;
        slot_d = slot_q;
        if (state_q == S_IDLE) begin
            i_d    = '0;
            slot_d = pos_i;
        end else if (state_q == S_WR) begin
            i_d = i_q + 1'b1;
        end
    end

    assign mem_addr_d  = MEM_BASE + MEM_AW'(i_d);
    assign disk_addr_d = {slot_d, i_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            slot_q   <= '0;
            dir_q    <= DIR_STORE;
            addr_p_q <= MEM_BASE;
            addr_s_q <= '0;
            data_p_q <= '0;
            data_s_q <= '0;
            tr_p_q   <= 1'b0;
            tr_s_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tr_p_q <= 1'b0;
            tr_s_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (std_i || ldd_i) begin
                        state_q <= S_RD;
                        slot_q  <= pos_i;
                        dir_q   <= std_i ? DIR_STORE : DIR_LOAD;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        if (std_i) addr_p_q <= mem_addr_d;
                        else       addr_s_q <= disk_addr_d;
                    end
                end
                S_RD: begin
                    state_q <= S_WR;
                    if (dir_q == DIR_STORE) begin
                        addr_s_q <= disk_addr_d;
                        tr_s_q   <= 1'b1;
                    end else begin
                        addr_p_q <= mem_addr_d;
                        tr_p_q   <= 1'b1;
                    end
                end
                S_WR: begin
                    // Keep the written word so data outputs hold it once tr drops.
                    if (dir_q == DIR_STORE) data_s_q <= q_p_i;
                    else                    data_p_q <= q_s_i;
                    if (i_q == I_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RD;
                        i_q     <= i_d;
                        if (dir_q == DIR_STORE) addr_p_q <= mem_addr_d;
                        else                    addr_s_q <= disk_addr_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write data is the source's own registered read port, valid exactly in WR.
    assign addr_p_o = addr_p_q;
    assign addr_s_o = addr_s_q;
    assign data_p_o = tr_p_q ? q_s_i : data_p_q;
    assign data_s_o = tr_s_q ? q_p_i : data_s_q;
    assign tr_p_o   = tr_p_q;
    assign tr_s_o   = tr_s_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: doc/page_swap_controller.md
Name: page_swap_controller

Overview:
- Parametrised successor to the primary-memory/disk transfer controller.
- Moves one whole page between the primary memory page window and a numbered disk slot.
  - `std`: store, memory → disk.
  - `ldd`: load, disk → memory.
- Driven by the processor's `std`/`ldd` strobes; sits between the `Memoria` transfer port and the `Disco` port.
- Adds over the previous controller: configurable word width, page size and slot count, latched slot number, `busy`/`done` handshake, defined collision behaviour.

Parameters:
- DW, 16, data word width (memory and disk).
- MEM_AW, 16, primary memory address width.
- DISK_AW, 15, disk address width.
- PAGE_W, 8, log2 of words per page; N = 2^PAGE_W.
- POS_W, DISK_AW-PAGE_W, slot index width (derived, do not override).
- MEM_BASE, 16'hFF00, base address of the page window; must be N-aligned and MEM_BASE+N-1 < 2^MEM_AW.

Ports:
- clk     input   1        single clock, rising edge
- rst_n   input   1        asynchronous active-low reset
- std     input   1        store request, level sampled in IDLE
- ldd     input   1        load request, level sampled in IDLE
- pos     input   POS_W    disk slot number, latched on accepted request
- addr_p  output  MEM_AW   memory transfer address
- data_p  output  DW       memory write data
- tr_p    output  1        memory write enable
- q_p     input   DW       memory read data, 1-cycle synchronous latency
- addr_s  output  DISK_AW  disk address
- data_s  output  DW       disk write data
- tr_s    output  1        disk write enable
- q_s     input   DW       disk read data, 1-cycle synchronous latency
- busy    output  1        transfer in progress
- done    output  1        one-cycle pulse, transfer complete

Behaviour:
- Reset (async, immediate):
  - State returns to IDLE.
  - `busy`, `done`, `tr_p`, `tr_s` = 0.
  - `addr_p` = MEM_BASE, `addr_s` = 0, `data_p` = `data_s` = 0.
  - Word counter `i` = 0, latched slot = 0, direction = store.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `std`=1 → latch `pos` and dir=store, `i`=0, go RD.
  - Else `ldd`=1 → latch `pos` and dir=load, go RD.
  - `std` has priority when both are high; `ldd` is dropped.
- RD (one cycle):
  - Drive the source address; both `tr` = 0.
  - Store source: `addr_p` = MEM_BASE+i.
  - Load source: `addr_s` = {slot,i}.
- WR (one cycle):
  - Drive the destination address; data = registered source `q`; destination `tr` = 1.
  - Store destination: `addr_s` = {slot,i}, `data_s` = `q_p`, `tr_s`=1.
  - Load destination: `addr_p` = MEM_BASE+i, `data_p` = `q_s`, `tr_p`=1.
  - If `i` = N-1 go DONE, else `i`++ and go RD.
- DONE (one cycle): `done`=1, `busy`=0, then IDLE.
- Handshake:
  - `busy`=1 in RD and WR only.
  - Requests while not IDLE (including DONE) are ignored, not queued.
  - A request held high through DONE restarts in the following IDLE cycle.
- Latency: request sampled at edge T0 → RD at T1 → `done` high in cycle T0+2N+1.
  - Exactly N destination writes occur; source `tr` is never asserted.
- Width rules:
  - `{slot,i}` is exactly DISK_AW bits, so no wrap is possible.
  - `i` counts 0..N-1 only, never wraps mid-transfer.
  - Memory address is MEM_BASE+i, never outside the window.
- Changes to `pos` or `std`/`ldd` during a transfer have no effect.
- Reset mid-transfer: abort immediately, no `done` pulse; destination keeps the words already written (no rollback).
- Outputs are registered; `addr`/`data` hold their last value in IDLE, except `tr` = 0.

Test Plan:
- PAGE_W=2, DW=16, MEM_BASE=16'hFF00; memory FF00..FF03 = 1111,2222,3333,4444; pulse `std` with `pos`=5 → disk 0x14..0x17 = 1111..4444; `done` at T0+9; exactly 4 `tr_s` pulses; `tr_p` never high.
- Disk slot 3 preloaded with A0A0,B1B1,C2C2,D3D3; pulse `ldd` with `pos`=3 → memory FF00..FF03 match; `busy` high for 8 cycles; one `done`.
- `std` and `ldd` high in the same cycle → store only; memory unchanged; `ldd` not serviced afterwards.
- Change `pos` 5→9 and pulse `ldd` during a store → store completes to slot 5; no load runs; slot 9 untouched.
- Assert `rst_n`=0 after the 2nd write of a store → `tr_s`/`busy` drop asynchronously; no `done`; disk 0x14,0x15 written, 0x16,0x17 unchanged.
- Hold `std` high continuously → back-to-back transfers, each `done` followed by RD two cycles later (DONE→IDLE→RD).
